// File: rtl/result_requantizer.sv
// Output stage of the 2x2 systolic array: captures four accumulations, applies
// optional ReLU, requantizes each to saturated int8 and buffers the bytes in a FIFO.
module result_requantizer #(
  parameter int ACC_W = 12,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    capture,
  input  logic signed [ACC_W-1:0] c00,
  input  logic signed [ACC_W-1:0] c01,
  input  logic signed [ACC_W-1:0] c10,
  input  logic signed [ACC_W-1:0] c11,
  input  logic                    activation,
  input  logic [3:0]              shift,
  input  logic                    rd_en,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    sat_flag,
  output logic                    drop_flag
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [3:0]    SHIFT_MAX  = 4'(ACC_W - 1);
  localparam logic [PW:0]   ACCEPT_MAX = (PW+1)'(DEPTH - 4);
  localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t                  state_r, state_next_s;
  logic signed [ACC_W-1:0] stage_r [4];
  logic                    act_r;
  logic [3:0]              shift_r;
  logic [1:0]              idx_r;
  logic [7:0]              mem_r [DEPTH];
  logic [PW-1:0]           wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [PW:0]             count_r, count_next_s;
  logic [7:0]              data_r, data_next_s;
  logic                    valid_r, sat_r, drop_r;
  logic                    accept_s, drop_s, push_s, pop_s;
  logic [8:0]              q_s;

  // Returns {clipped, byte}; all arithmetic is one bit wider than the accumulator
  // so that rounding up 2^(ACC_W-1)-1 cannot wrap negative.
  function automatic logic [8:0] quantize(input logic signed [ACC_W-1:0] elem,
                                          input logic relu, input logic [3:0] sh);
    logic signed [ACC_W:0] v;
    logic signed [ACC_W:0] rnd;
    logic                  clip;
    v   = {elem[ACC_W-1], elem};
    rnd = '0;
    if (relu && v[ACC_W]) v = '0;
    else v = v;
    if (sh != 4'd0) begin
      rnd[sh - 4'd1] = 1'b1;
      v = (v + rnd) >>> sh;
    end else begin
      rnd = '0;
    end
    clip = ~((&v[ACC_W:7]) | (~|v[ACC_W:7]));
    if (clip) quantize = {1'b1, (v[ACC_W] ? 8'h80 : 8'h7F)};
    else quantize = {1'b0, v[7:0]};
  endfunction

  assign q_s = quantize(stage_r[idx_r], act_r, shift_r);

  // Next state, capture acceptance, push/pop decisions and FIFO bookkeeping
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    drop_s       = 1'b0;
    push_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (capture && (count_r <= ACCEPT_MAX)) begin
          accept_s     = 1'b1;
          state_next_s = CONV;
        end else if (capture) begin
          drop_s = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      CONV: begin
        push_s = 1'b1;
        if (capture) drop_s = 1'b1;
        else drop_s = 1'b0;
        if (idx_r == 2'd3) state_next_s = IDLE;
        else state_next_s = CONV;
      end
      default: state_next_s = IDLE;
    endcase
    if (clear) begin
      state_next_s = IDLE;
      accept_s     = 1'b0;
      drop_s       = 1'b0;
      push_s       = 1'b0;
    end else begin
      state_next_s = state_next_s;
    end

    if (!clear && rd_en && (count_r != '0)) pop_s = 1'b1;
    else pop_s = 1'b0;
    rd_next_s = rd_ptr_r + PTR_ONE;

    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
    if (clear) count_next_s = '0;
    else count_next_s = count_next_s;

    // Show-ahead head byte: the next entry after a pop, or the byte being pushed
    // when it lands in (or straight through) an otherwise empty FIFO.
    data_next_s = data_r;
    if (clear) begin
      data_next_s = 8'h00;
    end else if (pop_s) begin
      if (count_r > CNT_ONE) data_next_s = mem_r[rd_next_s];
      else if (push_s) data_next_s = q_s[7:0];
      else data_next_s = 8'h00;
    end else if (push_s && (count_r == '0)) begin
      data_next_s = q_s[7:0];
    end else begin
      data_next_s = data_r;
    end
  end

  // Control state, staging registers and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= 2'd0;
      act_r   <= 1'b0;
      shift_r <= 4'd0;
      for (int i = 0; i < 4; i++) stage_r[i] <= '0;
      sat_r   <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (clear) begin
        idx_r <= 2'd0;
      end else if (accept_s) begin
        stage_r[0] <= c00;
        stage_r[1] <= c01;
        stage_r[2] <= c10;
        stage_r[3] <= c11;
        act_r      <= activation;
        shift_r    <= (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
        idx_r      <= 2'd0;
      end else if (push_s) begin
        idx_r <= idx_r + 2'd1;
      end else begin
        idx_r <= idx_r;
      end
      if (clear) begin
        sat_r  <= 1'b0;
        drop_r <= 1'b0;
      end else begin
        if (drop_s) drop_r <= 1'b1;
        if (push_s && q_s[8]) sat_r <= 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy and registered head byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      data_r   <= 8'h00;
      valid_r  <= 1'b0;
    end else begin
      if (clear) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
        if (pop_s) rd_ptr_r <= rd_next_s;
      end
      count_r <= count_next_s;
      data_r  <= data_next_s;
      valid_r <= (count_next_s != '0);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= q_s[7:0];
  end

  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign busy      = (state_r == CONV);
  assign count     = count_r;
  assign sat_flag  = sat_r;
  assign drop_flag = drop_r;

endmodule

// File: doc/result_requantizer.md
# result_requantizer

Downstream stage of the 2x2 systolic array. It captures the four signed accumulator results when a result set is valid and applies optional ReLU. It then requantizes each result to int8 (rounded arithmetic right shift with saturation) and queues the bytes in a small FIFO that the host drains one byte per read strobe. This replaces direct byte-selection of raw accumulations on the output pins with a buffered, saturating int8 stream.

## Interface
- ACC_W, 12, accumulator width (signed two's complement)
- DEPTH, 8, FIFO entries (power of two, >= 4; holds two result sets)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush: empties FIFO, aborts conversion, clears sticky flags
- capture  in  1  one-cycle pulse: c00..c11 valid this cycle
- c00, c01, c10, c11  in  ACC_W each  signed accumulations
- activation  in  1  ReLU enable, sampled at capture
- shift  in  4  right-shift amount, sampled at capture; values > ACC_W-1 treated as ACC_W-1
- rd_en  in  1  pop FIFO head
- out_data  out  8  FIFO head byte (show-ahead), 0 when empty
- out_valid  out  1  FIFO non-empty
- busy  out  1  conversion in progress
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- sat_flag  out  1  sticky: some element clipped since last clear/reset
- drop_flag  out  1  sticky: some capture rejected since last clear/reset

## Operation
- States: IDLE, CONV. Reset and clear force IDLE.
- IDLE: capture is accepted only if DEPTH - count >= 4. An accepted capture latches c00,c01,c10,c11 into staging, latches activation and shift, clears the element index, and moves to CONV. A rejected capture sets drop_flag and leaves staging, state and FIFO unchanged.
- CONV: one element per cycle in row-major order c00, c01, c10, c11. The element is quantized and pushed to FIFO. After the 4th push, return to IDLE. Any capture during CONV is rejected and sets drop_flag.
- Quantize, computed in ACC_W+1 bits signed:
  - v = element; if activation and v < 0, v = 0.
  - If shift > 0, v = (v + (1 << (shift-1))) >>> shift (round half up); shift 0 passes v unchanged.
  - Saturate to [-128, 127]. Clipping sets sat_flag.
- FIFO: circular, separate wr/rd pointers wrap modulo DEPTH. count tracks occupancy.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - rd_en while empty is ignored.
  - Overflow cannot occur, because capture reserves 4 slots and a push is issued only from CONV.
- clear has priority over capture, rd_en and conversion in the same cycle.

## Timing
- Reset values:
  - out_data, count, busy, out_valid, sat_flag, drop_flag all 0; state IDLE.
  - Pointers and element index 0.
- capture high in cycle N (accepted):
  - busy high in cycles N+1..N+4.
  - Pushes occur at the edges ending cycles N+1..N+4.
  - out_valid high from cycle N+2 if the FIFO was empty.
  - All four bytes are present by cycle N+5.
  - A new capture is accepted from cycle N+5.
- out_data is registered show-ahead and updates the cycle after a push into an empty FIFO or after a pop.
- rd_en high in cycle M with out_valid: the next byte (or 0 if empty) is visible in M+1.
- Flags set the cycle after the causing event and hold until clear or rst.
- rst asserted mid-CONV: immediate return to reset values. Partial results are discarded.

## Test plan
- shift=0, activation=0, results {5, -3, 127, 200}, capture -> bytes popped in order 0x05, 0xFD, 0x7F, 0x7F; sat_flag=1, drop_flag=0.
- shift=2, activation=0, {6, -6, 2047, -2048} -> 0x02, 0xFF, 0x7F, 0x80; verify 2047 rounding does not wrap.
- activation=1, shift=4, {-100, 40, 8, 7} -> 0x00, 0x03, 0x01, 0x00; sat_flag stays 0.
- Two captures without popping fill 8 entries -> third capture rejected, drop_flag=1, count stays 8. A capture issued during busy is likewise rejected.
- Pop one byte per cycle while a second result set converts -> count never exceeds 7 and byte order is preserved across pointer wrap.
- rst asserted at cycle N+2 of a conversion -> all outputs 0 next cycle. clear with 4 entries queued -> count 0, out_valid 0, flags cleared.
